// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit datapath.
// Sequences fetch / decode / execute / memory / write-back per instruction,
// drives the datapath enables and one shared memory port (req/ready), counts
// retired instructions and traps a memory port that never answers.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             alu_src,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   // wait_cnt only has to reach MEM_TIMEOUT-1
   localparam int            WW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

   state_t           st, nxt;
   logic [3:0]       op_q;
   logic [WW-1:0]    wait_cnt;
   logic [CNT_W-1:0] ret_q;
   logic             retire;

   // Per-state enables, next state and retire strobe; everything is forced
   // to 0 while reset is held so no enable leaks out of an abandoned instruction.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      alu_src      = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 1'b0;
      halted       = 1'b0;
      fault        = 1'b0;
      nxt          = st;
      retire       = 1'b0;
      case (st)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_we   = 1'b1;
               nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            // op_q is not loaded yet, so steer on the live IR field
            if (opcode == OP_HALT) begin
               nxt    = S_HALT;
               retire = 1'b1;
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!op_q[3]) begin
               nxt = S_WB;
            end else if (op_q == OP_LW || op_q == OP_SW) begin
               alu_src = 1'b1;
               nxt     = S_MEM;
            end else begin
               if (op_q == OP_BEQ) begin
                  pc_we  = alu_zero;
                  pc_src = 2'b01;
               end else if (op_q == OP_JMP) begin
                  pc_we  = 1'b1;
                  pc_src = 2'b10;
               end
               nxt    = S_FETCH;
               retire = 1'b1;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            alu_src      = 1'b1;
            mem_we       = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_SW) begin
                  nxt    = S_FETCH;
                  retire = 1'b1;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_sel = (op_q == OP_LW);
            nxt    = S_FETCH;
            retire = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: nxt = S_FETCH;
      endcase
      // a ready on the last allowed cycle is not a timeout
      if (MEM_TIMEOUT != 0 && mem_req && !mem_ready && wait_cnt == LAST)
         nxt = S_FAULT;
      state   = st;
      retired = ret_q;
      if (reset) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         ir_load      = 1'b0;
         pc_we        = 1'b0;
         pc_src       = 2'b00;
         alu_src      = 1'b0;
         reg_we       = 1'b0;
         wb_sel       = 1'b0;
         halted       = 1'b0;
         fault        = 1'b0;
         state        = 3'd0;
         retired      = '0;
      end
   end

   // State, opcode latch, unanswered-request counter and retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= S_FETCH;
         op_q     <= 4'h0;
         wait_cnt <= '0;
         ret_q    <= '0;
      end else begin
         st <= nxt;
         if (st == S_DECODE) op_q <= opcode;
         if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
         else                       wait_cnt <= '0;
         if (retire) ret_q <= ret_q + 1'b1;
      end
   end

endmodule
